// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsupported size encodings (including unsigned stores) count as misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset,
                                         input logic       is_store);
    case (funct3)
      F3_B:    is_misaligned = 1'b0;
      F3_BU:   is_misaligned = is_store;
      F3_H:    is_misaligned = offset[0];
      F3_HU:   is_misaligned = is_store | offset[0];
      F3_W:    is_misaligned = |offset;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory valid/ready port between the load/store unit and memory.
interface mem_access_unit_if #(parameter int XLEN = 32);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Load data formatter: picks the byte/half lane by address offset and
// sign- or zero-extends it to XLEN.
module load_formatter
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select followed by extension according to access type.
  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane_b};
      F3_H:    data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with MEM/WB register.
// Optional build macro DMEM_TIMEOUT_EN: aborts accesses that wait
// TIMEOUT_CYCLES cycles and pulses dmem_timeout_o.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic             valid_in,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  mem_access_unit_if.master dmem,
  output logic             StallM,
  output logic             misalign_o,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [4:0]       RdW,
  output logic             valid_out
`ifdef DMEM_TIMEOUT_EN
  ,
  output logic             dmem_timeout_o
`endif
);

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  mem_state_t      state, state_nxt;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            we_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mem_op, bad_align, start, busy, done, misal, timeout;
  logic [XLEN-1:0] ld_data;

  assign mem_op    = valid_in & (MemReadM | MemWriteM);
  assign bad_align = is_misaligned(Funct3M, ALUResultM[1:0], MemWriteM);

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .rdata  (dmem.dmem_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .data   (ld_data)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Wait-cycle counter, cleared whenever the FSM sits in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else                    to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) & ~done & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // One-cycle abort indication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dmem_timeout_o <= 1'b0;
    else        dmem_timeout_o <= timeout;
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, request drive and completion decode.
  always_comb begin
    state_nxt           = state;
    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_addr      = addr_q;
    dmem.dmem_we        = we_q;
    dmem.dmem_wdata     = wdata_q;
    dmem.dmem_wstrb     = wstrb_q;
    start               = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    misal               = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (bad_align) begin
            misal = 1'b1;
          end else begin
            busy                = 1'b1;
            start               = 1'b1;
            dmem.dmem_req_valid = 1'b1;
            dmem.dmem_addr      = {ALUResultM[XLEN-1:2], 2'b00};
            dmem.dmem_we        = MemWriteM;
            dmem.dmem_wdata     = store_data(Funct3M, WriteDataM);
            dmem.dmem_wstrb     = store_strb(Funct3M, ALUResultM[1:0]);
            if (dmem.dmem_req_ready) begin
              if (MemWriteM) done = 1'b1;
              else           state_nxt = RESP;
            end else begin
              state_nxt = REQ;
            end
          end
        end
      end
      REQ: begin
        busy                = 1'b1;
        dmem.dmem_req_valid = 1'b1;
        if (dmem.dmem_req_ready) begin
          if (we_q) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        busy = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  assign StallM = busy & ~done & ~timeout;

  // Capture request fields and load format on the first cycle of an access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else if (start) begin
      addr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
      wdata_q <= store_data(Funct3M, WriteDataM);
      we_q    <= MemWriteM;
      wstrb_q <= store_strb(Funct3M, ALUResultM[1:0]);
      f3_q    <= Funct3M;
      off_q   <= ALUResultM[1:0];
    end
  end

  // MEM/WB boundary: retire on non-stalled cycles, bubble while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_o <= 1'b0;
      valid_out  <= 1'b0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
    end else begin
      misalign_o <= misal;
      if (!StallM) begin
        valid_out  <= valid_in & ~misal & ~timeout;
        ReadDataW  <= ld_data;
        ALUResultW <= ALUResultM;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
      end else begin
        valid_out  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the 5-stage RV32 pipeline; consumes the EX/MEM register outputs (ALU result, store data, rd, PC+4, valid).
- Drives a valid/ready data-memory port with byte strobes, formats load data, stalls the pipeline on multi-cycle accesses.
- Contains the MEM/WB pipeline register feeding writeback.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, response-wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ALUResultM  in  XLEN  effective address, or ALU result to pass through.
- WriteDataM  in  XLEN  store data (rs2).
- RdM  in  5  destination register.
- PCPlus4M  in  XLEN  link value.
- valid_in  in  1  MEM-stage instruction valid.
- MemReadM / MemWriteM  in  1 each  load / store.
- Funct3M  in  3  access size/sign.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_we  out  1  write request.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- StallM  out  1  freeze PC/IF/ID/EX and EX/MEM.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- ReadDataW, ALUResultW, PCPlus4W  out  XLEN  MEM/WB outputs.
- RdW  out  5  destination register.
- valid_out  out  1  WB instruction valid.

Behaviour:
- Reset (async, reset low): state=IDLE; all outputs 0, including the MEM/WB register, valid_out, StallM and misalign_o.
- mem_op = valid_in & (MemReadM | MemWriteM).
- Misaligned when halfword and addr[0]=1, or word and addr[1:0]≠0.
  - Misaligned op: no request issued; misalign_o=1 for one cycle; instruction retires to WB with valid_out=0.
  - Illegal Funct3 is treated as misaligned.
- Stores: SB strobe 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111. wdata replicates byte/half across lanes.
- FSM:
  - IDLE:
    - aligned mem_op: dmem_req_valid=1 combinationally.
    - If ready and store: done this cycle, no stall.
    - If ready and load: go to RESP.
    - If not ready: go to REQ.
    - Non-mem or invalid op: passes straight through, no stall.
  - REQ: hold addr, we, wdata, wstrb stable with valid=1 until ready. Store → IDLE (done). Load → RESP.
  - RESP: wait for dmem_rsp_valid; done that cycle → IDLE.
    - A response arriving in the same cycle as acceptance is not allowed (minimum load latency 1 cycle).
- StallM = mem_op & aligned & ~done. EX/MEM inputs are held upstream while stalled.
- Request fields and Funct3/addr[1:0] are latched on the first cycle of an access; the response is formatted from the latched values.
- Load format:
  - LB/LH: select lane by offset, sign-extend.
  - LBU/LHU: select lane by offset, zero-extend.
  - LW: whole word.
- MEM/WB register, every non-stalled cycle: latches ALUResult, Rd, PCPlus4, formatted read data; valid_out=valid_in & ~misaligned.
- MEM/WB register, stalled cycles: loads a bubble (valid_out=0; other fields don't-care, held).
- Reset mid-access: returns to IDLE. A late dmem_rsp_valid while in IDLE is ignored.
- Latency:
  - Non-mem op or zero-wait store: 1 cycle (register only).
  - Load: accept cycle + response wait, with StallM high throughout.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter counts cycles in REQ/RESP and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, drop StallM, retire with valid_out=0, pulse output port dmem_timeout_o for 1 cycle.
  - A response arriving later is ignored.
- Undefined: no counter and no dmem_timeout_o port; waits indefinitely.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {IDLE, REQ, RESP}.
  - Funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - XLEN default.
- One sub-module, load_formatter: combinational lane select plus sign/zero extension.

Test Plan:
- ALUResultM=0x100, WriteDataM=0xAABBCCDD, SW, ready=1 → wstrb=1111, wdata=0xAABBCCDD, StallM=0, valid_out=1 next cycle.
- SB at 0x103, data 0x000000EE → addr=0x100, wstrb=1000, wdata=0xEEEEEEEE.
- LB at 0x101, ready=1, rsp after 3 cycles with rdata=0x12348056 → StallM high 4 cycles, ReadDataW=0xFFFFFF80. Same access as LBU → 0x00000080.
- LW at 0x102 → no request, misalign_o pulse, valid_out=0, StallM=0.
- ready low 2 cycles on SH at 0x202 → addr/wstrb=1100 stable for 3 cycles, StallM high 2 cycles.
- reset low during RESP, then rsp_valid arrives → IDLE, outputs 0, response ignored. With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no response → abort after 4 cycles, dmem_timeout_o pulse.
